// File: rtl/bcd_display_scanner_if.sv
// Time-word input and multiplexed display outputs of the stopwatch display scanner.
interface bcd_display_scanner_if;
  logic [16:1] Q;         // packed BCD MM:SS, Q[16:13]=min tens .. Q[4:1]=sec units
  logic        BLANK_LZ;  // blank minutes-tens digit when it is zero
  logic        RUN;       // colon blinks when 1, solid when 0
  logic [6:0]  SEG;       // {g,f,e,d,c,b,a}, active-low
  logic        DP;        // colon, active-low
  logic [3:0]  AN;        // one-hot active-low anodes, AN[3]=min tens
  logic        ERR;       // sticky invalid-BCD flag

  // Time source side: drives the time word and mode bits, observes the display.
  modport master (
    output Q, BLANK_LZ, RUN,
    input  SEG, DP, AN, ERR
  );

  // Scanner side.
  modport slave (
    input  Q, BLANK_LZ, RUN,
    output SEG, DP, AN, ERR
  );
endinterface

// File: rtl/bcd_display_scanner.sv
// 4-digit common-anode 7-segment scanner with dead-time, frame snapshot and blinking colon.
module bcd_display_scanner #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned DEAD_CYC     = 16,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                   clk_in,
  input  logic                   RESET,
  bcd_display_scanner_if.slave   bus
);

  localparam int unsigned CW = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYC);
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  typedef enum logic [1:0] {D0, D1, D2, D3} slot_e;
  typedef enum logic {PH_OFF, PH_ON} phase_e;

  logic [CW-1:0] cnt_q,   cnt_d;
  slot_e         slot_q,  slot_d;
  logic [16:1]   snap_q,  snap_d;
  logic [FW-1:0] frm_q,   frm_d;
  phase_e        phase_q, phase_d;
  logic          err_q,   err_d;
  logic [6:0]    seg_q,   seg_d;
  logic          dp_q,    dp_d;
  logic [3:0]    an_q,    an_d;

  logic          slot_end;
  logic          frame_end;
  logic          in_dead;
  logic [3:0]    nib;

  // Active-low 7-segment glyph for a BCD nibble; anything above 9 renders as a dash.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    g = SEG_DASH;
    case (n)
      4'd0: g = 7'b1000000;
      4'd1: g = 7'b1111001;
      4'd2: g = 7'b0100100;
      4'd3: g = 7'b0110000;
      4'd4: g = 7'b0011001;
      4'd5: g = 7'b0010010;
      4'd6: g = 7'b0000010;
      4'd7: g = 7'b1111000;
      4'd8: g = 7'b0000000;
      4'd9: g = 7'b0010000;
      default: g = SEG_DASH;
    endcase
    return g;
  endfunction

  // True when any of the four nibbles is outside 0..9.
  function automatic logic has_bad_nibble(input logic [16:1] w);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (w[4*i+1 +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Next state for prescaler, slot, snapshot, blink and error; outputs from the next state
  // so the registered display lines up with the count it belongs to.
  always_comb begin
    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (slot_q == D3);

    cnt_d   = slot_end ? '0 : cnt_q + CW'(1);
    slot_d  = slot_q;
    snap_d  = snap_q;
    frm_d   = frm_q;
    phase_d = phase_q;
    err_d   = err_q;

    if (slot_end) begin
      case (slot_q)
        D0:      slot_d = D1;
        D1:      slot_d = D2;
        D2:      slot_d = D3;
        default: slot_d = D0;
      endcase
    end

    // Frame boundary: latch the whole time word so no digit is torn mid-frame.
    if (frame_end) begin
      snap_d = bus.Q;
      if (has_bad_nibble(bus.Q)) err_d = 1'b1;
    end

    // Colon blink cadence only runs while the stopwatch runs.
    if (!bus.RUN) begin
      frm_d   = '0;
      phase_d = PH_ON;
    end else if (frame_end) begin
      if (frm_q == FRM_LAST) begin
        frm_d   = '0;
        phase_d = (phase_q == PH_ON) ? PH_OFF : PH_ON;
      end else begin
        frm_d = frm_q + FW'(1);
      end
    end

    nib = 4'd0;
    case (slot_d)
      D0:      nib = snap_d[4:1];
      D1:      nib = snap_d[8:5];
      D2:      nib = snap_d[12:9];
      default: nib = snap_d[16:13];
    endcase

    in_dead = (cnt_d < CNT_DEAD);

    if ((slot_d == D3) && bus.BLANK_LZ && (nib == 4'd0)) seg_d = SEG_OFF;
    else                                                 seg_d = glyph(nib);

    an_d = in_dead ? 4'hF : ~(4'b0001 << slot_d);
    dp_d = !((slot_d == D2) && !in_dead && (!bus.RUN || (phase_d == PH_ON)));
  end

  // State and output registers; reset blanks the display immediately.
  always_ff @(posedge clk_in or posedge RESET) begin
    if (RESET) begin
      cnt_q   <= '0;
      slot_q  <= D0;
      snap_q  <= 16'h0;
      frm_q   <= '0;
      phase_q <= PH_ON;
      err_q   <= 1'b0;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
      an_q    <= 4'hF;
    end else begin
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      snap_q  <= snap_d;
      frm_q   <= frm_d;
      phase_q <= phase_d;
      err_q   <= err_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  assign bus.SEG = seg_q;
  assign bus.DP  = dp_q;
  assign bus.AN  = an_q;
  assign bus.ERR = err_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with a short refresh period.
module tb_bcd_display_scanner;

  localparam int unsigned RD    = 8;
  localparam int unsigned DC    = 2;
  localparam int unsigned BF    = 2;
  localparam int          FRAME = 4 * RD;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G9 = 7'b0010000;
  localparam logic [6:0] GD = 7'b0111111;
  localparam logic [6:0] GB = 7'h7F;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   pos      = 0;

  always #5 clk = ~clk;

  bcd_display_scanner_if dif();

  bcd_display_scanner #(
    .REFRESH_DIV (RD),
    .DEAD_CYC    (DC),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk_in(clk),
    .RESET (rst),
    .bus   (dif)
  );

  // Reset with given inputs; on return the DUT sits at frame 0, slot D0, count 0.
  task automatic do_reset(input logic [15:0] q, input logic blz, input logic run);
    @(negedge clk);
    dif.Q = q; dif.BLANK_LZ = blz; dif.RUN = run;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pos = 0;
  endtask

  // Advance to (frame, slot, count) measured from the last reset release.
  task automatic goto(input int f, input int s, input int c);
    int t;
    t = f * FRAME + s * RD + c;
    if (t < pos) begin
      $display("FAIL goto: target %0d behind position %0d", t, pos);
      $fatal(1, "bench sequencing error");
    end
    while (pos < t) begin
      @(negedge clk);
      pos++;
    end
  endtask

  task automatic test_reset;
    dif.Q = 16'h1234; dif.BLANK_LZ = 1'b0; dif.RUN = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (dif.SEG !== GB)      begin failures++; $display("FAIL reset_seg: got %b want %b", dif.SEG, GB); end
    checks++; if (dif.DP  !== 1'b1)    begin failures++; $display("FAIL reset_dp: got %b want 1", dif.DP); end
    checks++; if (dif.AN  !== 4'hF)    begin failures++; $display("FAIL reset_an: got %b want 1111", dif.AN); end
    checks++; if (dif.ERR !== 1'b0)    begin failures++; $display("FAIL reset_err: got %b want 0", dif.ERR); end
    rst = 1'b0;
    pos = 0;
    checks++; if (dif.AN  !== 4'hF)    begin failures++; $display("FAIL reset_an_pos0: got %b want 1111", dif.AN); end
  endtask

  // Continues from test_reset: frame 0 shows zeros, frame 1 shows 1234.
  task automatic test_scan;
    logic [6:0] exp1 [4];
    logic [3:0] an_exp;
    exp1 = '{G4, G3, G2, G1};
    for (int f = 0; f < 2; f++) begin
      for (int s = 0; s < 4; s++) begin
        an_exp = ~(4'b0001 << s);
        for (int c = 0; c < 2; c++) begin
          goto(f, s, c);
          checks++; if (dif.AN !== 4'hF) begin failures++; $display("FAIL scan_dead_an f%0d s%0d c%0d: got %b want 1111", f, s, c, dif.AN); end
          if (s == 2) begin
            checks++; if (dif.DP !== 1'b1) begin failures++; $display("FAIL scan_dead_dp f%0d c%0d: got %b want 1", f, c, dif.DP); end
          end
        end
        for (int c = 2; c < 8; c += 5) begin
          goto(f, s, c);
          checks++; if (dif.AN !== an_exp) begin failures++; $display("FAIL scan_an f%0d s%0d c%0d: got %b want %b", f, s, c, dif.AN, an_exp); end
          checks++; if (dif.SEG !== ((f == 0) ? G0 : exp1[s])) begin failures++; $display("FAIL scan_seg f%0d s%0d c%0d: got %b want %b", f, s, c, dif.SEG, (f == 0) ? G0 : exp1[s]); end
          checks++; if (dif.DP !== ((s == 2) ? 1'b0 : 1'b1)) begin failures++; $display("FAIL scan_dp f%0d s%0d c%0d: got %b want %b", f, s, c, dif.DP, (s == 2) ? 1'b0 : 1'b1); end
        end
      end
    end
    checks++; if (dif.ERR !== 1'b0) begin failures++; $display("FAIL scan_err: got %b want 0", dif.ERR); end
  endtask

  task automatic test_blank;
    logic [6:0] exp [4];
    exp = '{G0, G3, G9, GB};
    do_reset(16'h0930, 1'b1, 1'b0);
    for (int s = 0; s < 4; s++) begin
      goto(1, s, 3);
      checks++; if (dif.SEG !== exp[s]) begin failures++; $display("FAIL blank_seg s%0d: got %b want %b", s, dif.SEG, exp[s]); end
    end
    checks++; if (dif.AN !== 4'b0111) begin failures++; $display("FAIL blank_an: got %b want 0111", dif.AN); end
    goto(1, 3, 7);
    dif.BLANK_LZ = 1'b0;
    goto(2, 2, 3);
    checks++; if (dif.SEG !== G9) begin failures++; $display("FAIL blank_off_d2: got %b want %b", dif.SEG, G9); end
    goto(2, 3, 3);
    checks++; if (dif.SEG !== G0) begin failures++; $display("FAIL blank_off_d3: got %b want %b", dif.SEG, G0); end
    checks++; if (dif.AN !== 4'b0111) begin failures++; $display("FAIL blank_off_an: got %b want 0111", dif.AN); end
  endtask

  task automatic test_snapshot;
    logic [6:0] old_f [4];
    logic [6:0] new_f [4];
    old_f = '{G9, G5, G9, G0};
    new_f = '{G0, G0, G0, G1};
    do_reset(16'h0959, 1'b0, 1'b0);
    goto(1, 0, 3);
    checks++; if (dif.SEG !== old_f[0]) begin failures++; $display("FAIL snap_old s0: got %b want %b", dif.SEG, old_f[0]); end
    goto(1, 1, 3);
    dif.Q = 16'h1000;
    for (int s = 1; s < 4; s++) begin
      goto(1, s, 4);
      checks++; if (dif.SEG !== old_f[s]) begin failures++; $display("FAIL snap_old s%0d: got %b want %b", s, dif.SEG, old_f[s]); end
    end
    for (int s = 0; s < 4; s++) begin
      goto(2, s, 4);
      checks++; if (dif.SEG !== new_f[s]) begin failures++; $display("FAIL snap_new s%0d: got %b want %b", s, dif.SEG, new_f[s]); end
    end
  endtask

  task automatic test_blink;
    logic dp_exp;
    do_reset(16'h1234, 1'b0, 1'b1);
    for (int f = 0; f < 6; f++) begin
      dp_exp = ((f / 2) % 2 == 0) ? 1'b0 : 1'b1;
      goto(f, 1, 4);
      checks++; if (dif.DP !== 1'b1) begin failures++; $display("FAIL blink_d1 f%0d: got %b want 1", f, dif.DP); end
      goto(f, 2, 4);
      checks++; if (dif.DP !== dp_exp) begin failures++; $display("FAIL blink_d2 f%0d: got %b want %b", f, dif.DP, dp_exp); end
    end
    goto(6, 0, 0);
    dif.RUN = 1'b0;
    for (int f = 6; f < 8; f++) begin
      goto(f, 2, 4);
      checks++; if (dif.DP !== 1'b0) begin failures++; $display("FAIL solid_d2 f%0d: got %b want 0", f, dif.DP); end
    end
  endtask

  task automatic test_err;
    logic [6:0] exp [4];
    exp = '{G5, GD, G0, G0};
    do_reset(16'h00A5, 1'b0, 1'b0);
    goto(0, 3, 7);
    checks++; if (dif.ERR !== 1'b0) begin failures++; $display("FAIL err_before: got %b want 0", dif.ERR); end
    goto(1, 0, 0);
    checks++; if (dif.ERR !== 1'b1) begin failures++; $display("FAIL err_set: got %b want 1", dif.ERR); end
    for (int s = 0; s < 4; s++) begin
      goto(1, s, 3);
      checks++; if (dif.SEG !== exp[s]) begin failures++; $display("FAIL err_seg s%0d: got %b want %b", s, dif.SEG, exp[s]); end
      if (s == 1) dif.Q = 16'h0005;
    end
    goto(2, 1, 3);
    checks++; if (dif.SEG !== G0) begin failures++; $display("FAIL err_clean_seg: got %b want %b", dif.SEG, G0); end
    goto(3, 0, 0);
    checks++; if (dif.ERR !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b want 1", dif.ERR); end
    do_reset(16'h0005, 1'b0, 1'b0);
    checks++; if (dif.ERR !== 1'b0) begin failures++; $display("FAIL err_cleared: got %b want 0", dif.ERR); end
    goto(1, 0, 1);
    checks++; if (dif.ERR !== 1'b0) begin failures++; $display("FAIL err_stays_clear: got %b want 0", dif.ERR); end
  endtask

  task automatic test_reset_mid;
    do_reset(16'h1234, 1'b0, 1'b0);
    goto(1, 2, 4);
    checks++; if (dif.AN !== 4'b1011) begin failures++; $display("FAIL mid_pre_an: got %b want 1011", dif.AN); end
    checks++; if (dif.DP !== 1'b0)    begin failures++; $display("FAIL mid_pre_dp: got %b want 0", dif.DP); end
    rst = 1'b1;
    #1;
    checks++; if (dif.AN  !== 4'hF) begin failures++; $display("FAIL mid_async_an: got %b want 1111", dif.AN); end
    checks++; if (dif.SEG !== GB)   begin failures++; $display("FAIL mid_async_seg: got %b want %b", dif.SEG, GB); end
    checks++; if (dif.DP  !== 1'b1) begin failures++; $display("FAIL mid_async_dp: got %b want 1", dif.DP); end
    @(negedge clk);
    rst = 1'b0;
    pos = 0;
    goto(0, 0, 1);
    checks++; if (dif.AN !== 4'hF) begin failures++; $display("FAIL mid_restart_dead: got %b want 1111", dif.AN); end
    goto(0, 0, 2);
    checks++; if (dif.AN  !== 4'b1110) begin failures++; $display("FAIL mid_restart_an: got %b want 1110", dif.AN); end
    checks++; if (dif.SEG !== G0)      begin failures++; $display("FAIL mid_restart_seg: got %b want %b", dif.SEG, G0); end
    goto(0, 1, 2);
    checks++; if (dif.AN !== 4'b1101)  begin failures++; $display("FAIL mid_restart_d1: got %b want 1101", dif.AN); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blank();
    test_snapshot();
    test_blink();
    test_err();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
